// File: rtl/packet_serializer.sv
// Packet serializer: captures one scheduler-selected packet and replays it
// as a single AXI write-address beat followed by BEATS write-data beats,
// then pulses consumed so the scheduler can release its queue head.
// Every output comes straight from a flop; ready inputs only steer next state.
module packet_serializer #(
    parameter int HEADER_SIZE = 102,
    parameter int BEATS       = 4,
    parameter int STRB_SIZE   = 16,
    parameter int BEAT_SIZE   = 128,
    parameter int DATA_SIZE   = HEADER_SIZE + BEATS*STRB_SIZE + BEATS*BEAT_SIZE
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   selector_to_serializer_packet,
    input  logic                   scheduler_to_serializer_activate_signal,
    output logic                   serializer_to_scheduler_consumed,
    output logic [HEADER_SIZE-1:0] m_aw_header,
    output logic                   m_aw_valid,
    input  logic                   m_aw_ready,
    output logic [BEAT_SIZE-1:0]   m_w_data,
    output logic [STRB_SIZE-1:0]   m_w_strb,
    output logic                   m_w_last,
    output logic                   m_w_valid,
    input  logic                   m_w_ready,
    output logic                   busy
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam int DATA_BASE = HEADER_SIZE + BEATS*STRB_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s, cnt_inc_s;
    logic [DATA_SIZE-1:0]   pkt_r, pkt_s;
    logic                   consumed_r, consumed_s;
    logic                   aw_valid_r, aw_valid_s;
    logic                   w_valid_r, w_valid_s;
    logic                   w_last_r, w_last_s;
    logic                   busy_r, busy_s;
    logic [BEAT_SIZE-1:0]   w_data_r, w_data_s;
    logic [STRB_SIZE-1:0]   w_strb_r, w_strb_s;

    // Extract the data field of beat idx from a packed packet.
    function automatic logic [BEAT_SIZE-1:0] beat_data(input logic [DATA_SIZE-1:0] pkt,
                                                       input logic [CNT_W-1:0] idx);
        beat_data = pkt[DATA_BASE + int'(idx)*BEAT_SIZE +: BEAT_SIZE];
    endfunction

    // Extract the strobe field of beat idx from a packed packet.
    function automatic logic [STRB_SIZE-1:0] beat_strb(input logic [DATA_SIZE-1:0] pkt,
                                                       input logic [CNT_W-1:0] idx);
        beat_strb = pkt[HEADER_SIZE + int'(idx)*STRB_SIZE +: STRB_SIZE];
    endfunction

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cnt_inc_s  = cnt_r + CNT_W'(1);
        pkt_s      = pkt_r;
        consumed_s = 1'b0;
        aw_valid_s = aw_valid_r;
        w_valid_s  = w_valid_r;
        w_last_s   = w_last_r;
        busy_s     = busy_r;
        w_data_s   = w_data_r;
        w_strb_s   = w_strb_r;
        case (state_r)
            ST_IDLE: begin
                if (scheduler_to_serializer_activate_signal) begin
                    pkt_s      = selector_to_serializer_packet;
                    state_s    = ST_ADDR;
                    aw_valid_s = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            ST_ADDR: begin
                if (m_aw_ready) begin
                    aw_valid_s = 1'b0;
                    state_s    = ST_DATA;
                    cnt_s      = {CNT_W{1'b0}};
                    w_valid_s  = 1'b1;
                    w_data_s   = beat_data(pkt_r, {CNT_W{1'b0}});
                    w_strb_s   = beat_strb(pkt_r, {CNT_W{1'b0}});
                    w_last_s   = (LAST_BEAT == {CNT_W{1'b0}});
                end else begin
                    aw_valid_s = 1'b1;
                end
            end
            ST_DATA: begin
                if (m_w_ready) begin
                    if (cnt_r == LAST_BEAT) begin
                        // Counter saturates at the final beat.
                        w_valid_s  = 1'b0;
                        w_last_s   = 1'b0;
                        state_s    = ST_DONE;
                        consumed_s = 1'b1;
                    end else begin
                        cnt_s    = cnt_inc_s;
                        w_data_s = beat_data(pkt_r, cnt_inc_s);
                        w_strb_s = beat_strb(pkt_r, cnt_inc_s);
                        w_last_s = (cnt_inc_s == LAST_BEAT);
                    end
                end else begin
                    w_valid_s = 1'b1;
                end
            end
            ST_DONE: begin
                // Activate is ignored here; the next IDLE cycle is the capture point.
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
            default: begin
                state_s    = ST_IDLE;
                cnt_s      = {CNT_W{1'b0}};
                aw_valid_s = 1'b0;
                w_valid_s  = 1'b0;
                w_last_s   = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, counter, packet and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            pkt_r      <= {DATA_SIZE{1'b0}};
            consumed_r <= 1'b0;
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            w_last_r   <= 1'b0;
            busy_r     <= 1'b0;
            w_data_r   <= {BEAT_SIZE{1'b0}};
            w_strb_r   <= {STRB_SIZE{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pkt_r      <= pkt_s;
            consumed_r <= consumed_s;
            aw_valid_r <= aw_valid_s;
            w_valid_r  <= w_valid_s;
            w_last_r   <= w_last_s;
            busy_r     <= busy_s;
            w_data_r   <= w_data_s;
            w_strb_r   <= w_strb_s;
        end
    end

    assign serializer_to_scheduler_consumed = consumed_r;
    assign m_aw_header = pkt_r[HEADER_SIZE-1:0];
    assign m_aw_valid  = aw_valid_r;
    assign m_w_data    = w_data_r;
    assign m_w_strb    = w_strb_r;
    assign m_w_last    = w_last_r;
    assign m_w_valid   = w_valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_packet_serializer.sv
// Scoreboard bench for packet_serializer: the stimulus side pushes the
// expected AW header and W beats of every packet it issues; a negedge
// monitor pops and compares on each handshake and checks AXI stability.
module tb_packet_serializer;

    localparam int HS = 102;
    localparam int NB = 4;
    localparam int SS = 16;
    localparam int BS = 128;
    localparam int DS = HS + NB*SS + NB*BS;

    typedef struct packed {
        logic [BS-1:0] data;
        logic [SS-1:0] strb;
        logic          last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DS-1:0] packet = '0;
    logic          activate = 1'b0;
    logic          consumed;
    logic [HS-1:0] aw_header;
    logic          aw_valid;
    logic          aw_ready;
    logic [BS-1:0] w_data;
    logic [SS-1:0] w_strb;
    logic          w_last;
    logic          w_valid;
    logic          w_ready;
    logic          busy;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int cons_seen = 0;
    int cons_exp  = 0;
    int w_hs_cnt  = 0;
    int aw_mode = 0;   // 0 high, 1 random, 2 low, 3 pattern 1,0,0
    int w_mode  = 0;

    logic [HS-1:0] exp_aw_q[$];
    beat_t         exp_w_q[$];

    logic [HS-1:0] cur_hdr;
    logic [SS-1:0] cur_strb [NB];
    logic [BS-1:0] cur_data [NB];

    packet_serializer #(.HEADER_SIZE(HS), .BEATS(NB), .STRB_SIZE(SS), .BEAT_SIZE(BS)) dut (
        .clock(clock),
        .reset(reset),
        .selector_to_serializer_packet(packet),
        .scheduler_to_serializer_activate_signal(activate),
        .serializer_to_scheduler_consumed(consumed),
        .m_aw_header(aw_header),
        .m_aw_valid(aw_valid),
        .m_aw_ready(aw_ready),
        .m_w_data(w_data),
        .m_w_strb(w_strb),
        .m_w_last(w_last),
        .m_w_valid(w_valid),
        .m_w_ready(w_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int pat);
        case (mode)
            0: ready_for = 1'b1;
            1: ready_for = 1'($urandom_range(0, 1));
            2: ready_for = 1'b0;
            3: ready_for = (pat % 3 == 0);
            default: ready_for = 1'b1;
        endcase
    endfunction

    // Ready driver: applies the requested backpressure profile each cycle.
    initial begin
        int pat;
        pat = 0;
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            aw_ready = ready_for(aw_mode, pat);
            w_ready  = ready_for(w_mode, pat);
            pat++;
        end
    end

    // Reference model: lay the fields out as a packet and queue the expected replay.
    task automatic make_pkt(output logic [DS-1:0] p, input bit push);
        p = '0;
        p[HS-1:0] = cur_hdr;
        for (int k = 0; k < NB; k++) begin
            p[HS + k*SS +: SS] = cur_strb[k];
            p[HS + NB*SS + k*BS +: BS] = cur_data[k];
        end
        if (push) begin
            beat_t b;
            exp_aw_q.push_back(cur_hdr);
            for (int k = 0; k < NB; k++) begin
                b.data = cur_data[k];
                b.strb = cur_strb[k];
                b.last = (k == NB - 1);
                exp_w_q.push_back(b);
            end
            cons_exp++;
        end
    endtask

    task automatic rand_fields();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        cur_hdr = t[HS-1:0];
        for (int k = 0; k < NB; k++) begin
            cur_strb[k] = 16'($urandom());
            cur_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    // Present the current fields with a one-cycle activate; DUT must be idle.
    task automatic send_pkt();
        logic [DS-1:0] p;
        make_pkt(p, 1'b1);
        packet   = p;
        activate = 1'b1;
        step();
        activate = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(cons_seen == cons_exp && busy == 1'b0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) check("wait_done_timeout", 128'(cons_seen), 128'(cons_exp));
    endtask

    // Monitor: compare handshakes against the scoreboard and check AXI stability.
    initial begin
        logic          aw_stall, w_stall, prev_cons;
        logic [HS-1:0] sv_hdr;
        beat_t         sv_beat, got, exp_b;
        aw_stall = 1'b0;
        w_stall = 1'b0;
        prev_cons = 1'b0;
        sv_hdr = '0;
        sv_beat = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                aw_stall = 1'b0;
                w_stall = 1'b0;
                prev_cons = 1'b0;
            end else begin
                got = '{data: w_data, strb: w_strb, last: w_last};
                if (aw_stall) begin
                    check("aw_hold_valid", 128'(aw_valid), 128'(1));
                    check("aw_hold_header", 128'(aw_header), 128'(sv_hdr));
                end
                if (w_stall) begin
                    check("w_hold_valid", 128'(w_valid), 128'(1));
                    check("w_hold_data", got.data, sv_beat.data);
                    check("w_hold_strb_last", 128'({got.strb, got.last}), 128'({sv_beat.strb, sv_beat.last}));
                end
                if (aw_valid) check("w_before_aw", 128'(w_valid), 128'(0));
                if (aw_valid && aw_ready) begin
                    if (exp_aw_q.size() == 0) check("aw_unexpected", 128'(1), 128'(0));
                    else check("aw_header", 128'(aw_header), 128'(exp_aw_q.pop_front()));
                end
                if (w_valid && w_ready) begin
                    w_hs_cnt++;
                    if (exp_w_q.size() == 0) check("w_unexpected", 128'(1), 128'(0));
                    else begin
                        exp_b = exp_w_q.pop_front();
                        check("w_data", got.data, exp_b.data);
                        check("w_strb", 128'(got.strb), 128'(exp_b.strb));
                        check("w_last", 128'(got.last), 128'(exp_b.last));
                    end
                end
                if (consumed) begin
                    cons_seen++;
                    check("consumed_single", 128'(prev_cons), 128'(0));
                end
                aw_stall = aw_valid && !aw_ready;
                sv_hdr = aw_header;
                w_stall = w_valid && !w_ready;
                sv_beat = got;
                prev_cons = consumed;
            end
        end
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [DS-1:0] pa, pb, pj;
        int c0, w0;
        // Reset state.
        #3;
        check("rst_consumed", 128'(consumed), 128'(0));
        check("rst_aw", 128'({aw_valid, aw_header}), 128'(0));
        check("rst_w", 128'({w_valid, w_last, w_strb}), 128'(0));
        check("rst_wdata", w_data, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        step(); step();
        reset = 1'b1;
        step();

        // Single packet, ready tied high: exact cycle timing.
        cur_hdr = 102'h2A;
        for (int k = 0; k < NB; k++) begin
            cur_strb[k] = 16'hFFFF;
            cur_data[k] = 128'(k + 1);
        end
        send_pkt();
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_aw_c%0d", c), 128'(aw_valid), 128'(c == 1));
            check($sformatf("t1_wv_c%0d", c), 128'(w_valid), 128'(c >= 2 && c <= 5));
            check($sformatf("t1_wl_c%0d", c), 128'(w_last), 128'(c == 5));
            check($sformatf("t1_cons_c%0d", c), 128'(consumed), 128'(c == 6));
            check($sformatf("t1_busy_c%0d", c), 128'(busy), 128'(c >= 1 && c <= 6));
            step();
        end
        wait_done();

        // AW backpressure for five cycles.
        rand_fields();
        aw_mode = 2;
        send_pkt();
        for (int c = 1; c <= 5; c++) begin
            check("t2_aw_held", 128'(aw_valid), 128'(1));
            check("t2_no_w", 128'(w_valid), 128'(0));
            step();
        end
        aw_mode = 0;
        check("t2_aw_still", 128'(aw_valid), 128'(1));
        step();
        check("t2_first_beat", 128'({aw_valid, w_valid}), 128'(2'b01));
        wait_done();

        // W backpressure pattern 1,0,0.
        rand_fields();
        w_mode = 3;
        c0 = cons_seen;
        w0 = w_hs_cnt;
        send_pkt();
        wait_done();
        w_mode = 0;
        check("t3_handshakes", 128'(w_hs_cnt - w0), 128'(NB));
        check("t3_consumed", 128'(cons_seen - c0), 128'(1));

        // Activate held high across packets A and B.
        c0 = cons_seen;
        rand_fields();
        make_pkt(pa, 1'b1);
        rand_fields();
        make_pkt(pj, 1'b0);
        rand_fields();
        packet = pa;
        activate = 1'b1;
        step(); step();
        packet = pj;
        begin
            int n;
            n = 0;
            while (consumed !== 1'b1 && n < 50) begin
                step();
                n++;
            end
            check("t4_a_consumed_seen", 128'(consumed), 128'(1));
        end
        make_pkt(pb, 1'b1);
        packet = pb;
        step();
        check("t4_idle_gap", 128'(busy), 128'(0));
        step();
        check("t4_b_captured", 128'({busy, aw_valid}), 128'(2'b11));
        activate = 1'b0;
        wait_done();
        check("t4_two_consumed", 128'(cons_seen - c0), 128'(2));

        // Reset in the middle of the data phase.
        rand_fields();
        send_pkt();
        step(); step(); step();
        check("t5_beats_left", 128'(exp_w_q.size()), 128'(2));
        reset = 1'b0;
        #1;
        check("t5_rst_flags", 128'({consumed, aw_valid, w_valid, w_last, busy}), 128'(0));
        check("t5_rst_data", w_data, 128'(0));
        check("t5_rst_hdr_strb", 128'({aw_header, w_strb}), 128'(0));
        exp_w_q.delete();
        exp_aw_q.delete();
        cons_exp--;
        step(); step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("t5_no_consumed", 128'({consumed, busy}), 128'(0));
            step();
        end
        rand_fields();
        w0 = w_hs_cnt;
        send_pkt();
        wait_done();
        check("t5_full_packet", 128'(w_hs_cnt - w0), 128'(NB));

        // Strobe mapping.
        rand_fields();
        cur_strb[0] = 16'h0001;
        cur_strb[1] = 16'h0010;
        cur_strb[2] = 16'h0100;
        cur_strb[3] = 16'h1000;
        send_pkt();
        wait_done();

        // Randomized packets with random backpressure and gaps.
        for (int i = 0; i < 12; i++) begin
            rand_fields();
            aw_mode = int'($urandom_range(0, 1));
            w_mode  = int'($urandom_range(0, 1));
            send_pkt();
            wait_done();
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
        end
        aw_mode = 0;
        w_mode = 0;
        step(); step();

        check("end_aw_queue_empty", 128'(exp_aw_q.size()), 128'(0));
        check("end_w_queue_empty", 128'(exp_w_q.size()), 128'(0));
        check("end_consumed_count", 128'(cons_seen), 128'(cons_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Sits directly downstream of the non-AXI scheduling domain, in the serializer position.
- Takes the packet chosen by the scheduler (selector output) whenever the scheduler activate signal is high, and replays it on AXI write address and write data channels.
- Pulses consumed back to the scheduler once the last data beat is accepted, which releases the queue head.
- One packet in flight at a time.

Parameters:
- HEADER_SIZE, 102, width of the address/control header replayed on the AW channel
- BEATS, 4, data beats per packet
- STRB_SIZE, 16, strobe bits per beat
- BEAT_SIZE, 128, data bits per beat
- DATA_SIZE, HEADER_SIZE+BEATS*STRB_SIZE+BEATS*BEAT_SIZE, total packet width

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- selector_to_serializer_packet  in  DATA_SIZE  packet from selector; valid while activate is high
- scheduler_to_serializer_activate_signal  in  1  level; high = a packet is selected and presented
- serializer_to_scheduler_consumed  out  1  one-cycle pulse: packet fully sent
- m_aw_header  out  HEADER_SIZE  latched header
- m_aw_valid  out  1  AW valid
- m_aw_ready  in  1  AW ready
- m_w_data  out  BEAT_SIZE  current beat data
- m_w_strb  out  STRB_SIZE  current beat strobes
- m_w_last  out  1  high on final beat
- m_w_valid  out  1  W valid
- m_w_ready  in  1  W ready
- busy  out  1  high from capture until the consumed pulse, inclusive

Behaviour:
- Packet layout:
  - [HEADER_SIZE-1:0] = header.
  - Strobe k = bits HEADER_SIZE+k*STRB_SIZE upward.
  - Data k = bits HEADER_SIZE+BEATS*STRB_SIZE+k*BEAT_SIZE upward.
  - Beat 0 is sent first.
- Reset (reset=0, asynchronous):
  - State IDLE, beat counter 0, packet register 0.
  - All outputs 0: consumed, aw_valid, w_valid, w_last, busy, header, data, strb.
  - Asserting reset mid-transfer aborts the transfer with no consumed pulse; the packet stays queued upstream.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If activate=1, register the whole packet and go to ADDR.
  - m_aw_valid=1 and busy=1 from the next cycle (one-cycle capture latency).
- ADDR:
  - Hold aw_valid and header until m_aw_ready=1 is sampled.
  - On that handshake, drop aw_valid, go to DATA with beat counter 0.
  - W never starts before AW is accepted.
- DATA:
  - w_valid=1; data/strb are selected by the counter.
  - w_last = (counter==BEATS-1).
  - On a w_ready handshake: counter +1; if it was the last beat, drop w_valid and go to DONE.
  - Data/strb/last stay stable while valid=1 and ready=0 (AXI rule).
  - Back-to-back beats are allowed: one beat per cycle when ready is held high.
- DONE:
  - consumed=1 for exactly one cycle, then IDLE. busy is high during DONE.
- Activate and packet input are ignored in every state except IDLE.
  - activate held high through DONE does not cause a double capture: the first IDLE cycle after DONE is a capture opportunity only.
  - The scheduler must have lowered or re-evaluated activate by then, because the consumed pulse updates queue state in the same cycle.
- Beat counter width is $clog2(BEATS) and does not wrap past BEATS-1.
- Minimum packet period with ready tied high: 1 (capture) + 1 (AW) + BEATS + 1 (DONE) = 7 cycles for BEATS=4.
- No combinational path from input to output. Ready inputs affect only next state.

Test Plan:
- Single packet, ready tied high:
  - Stimulus: activate for 1 cycle with header=0x2A, strb k=0xFFFF, data k=k+1.
  - Required: aw_valid in cycle 1; beats 1,2,3,4 in cycles 2-5 with w_last only on data=4; consumed pulse in cycle 6; busy cycles 1-6.
- AW backpressure:
  - Stimulus: aw_ready low for 5 cycles.
  - Required: header held stable, w_valid=0 throughout; first beat the cycle after aw_ready=1.
- W backpressure:
  - Stimulus: w_ready toggling 1,0,0,1,...
  - Required: beat values unchanged during stalls; exactly 4 handshakes; last on 4th; single consumed pulse.
- Activate held high across two packets A and B:
  - Stimulus: packet changes to B right after consumed.
  - Required: A sent fully; the input change during busy is ignored; B captured in the first IDLE cycle; exactly two consumed pulses.
- Reset mid-DATA:
  - Stimulus: reset=0 after beat 2.
  - Required: all outputs 0 immediately (asynchronous); no consumed pulse; after release, the next activate sends a complete 4-beat packet from beat 0.
- Strobe mapping:
  - Stimulus: strb = 0x0001, 0x0010, 0x0100, 0x1000.
  - Required: the beats carry those strobes in that order.
